// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two valid/ready requesters
module alu_share_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CTRL_WIDTH = 6,
    parameter logic [CTRL_WIDTH-1:0] IDLE_CTRL  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req0_branch_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_branch,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic                  req1_branch_op,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_branch,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic [DATA_WIDTH-1:0] alu_operand_A,
    output logic [DATA_WIDTH-1:0] alu_operand_B,
    output logic                  alu_branch_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_branch,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nx;
    logic   rr, owner, accept, rsp_take;

    // grant, handshake and next-state decode; rr=1 favours port 1 when both request
    always_comb begin
        req0_ready = (state == IDLE) & req0_valid & (~req1_valid | ~rr);
        req1_ready = (state == IDLE) & req1_valid & (~req0_valid | rr);
        accept     = req0_ready | req1_ready;
        rsp_take   = owner ? rsp1_ready : rsp0_ready;
        busy       = state != IDLE;
        state_nx   = state;
        case (state)
            IDLE:    state_nx = accept ? ISSUE : IDLE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = rsp_take ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // operand latches double as the ALU drive; response registers held until consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr            <= 1'b0;
            owner         <= 1'b0;
            alu_control   <= IDLE_CTRL;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            alu_branch_op <= 1'b0;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_branch   <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_branch   <= 1'b0;
        end else begin
            if (accept) begin
                owner         <= req1_ready;
                alu_control   <= req1_ready ? req1_ctrl : req0_ctrl;
                alu_operand_A <= req1_ready ? req1_a : req0_a;
                alu_operand_B <= req1_ready ? req1_b : req0_b;
                alu_branch_op <= req1_ready ? req1_branch_op : req0_branch_op;
            end
            if (state == ISSUE) begin
                rr            <= ~owner;
                alu_control   <= IDLE_CTRL;
                alu_operand_A <= '0;
                alu_operand_B <= '0;
                alu_branch_op <= 1'b0;
                if (owner) begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= alu_result;
                    rsp1_branch <= alu_branch;
                end else begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= alu_result;
                    rsp0_branch <= alu_branch;
                end
            end
            if (state == RESP && rsp_take) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
        end
    end
endmodule
